// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: merges per-stage stall/flush requests into stage
// controls and a PC redirect, with a timed stall hold, perf counters and a watchdog.
module hazard_ctrl #(
  parameter int NUM_STAGES = 5,
  parameter int PC_WIDTH   = 32,
  parameter int HOLD_WIDTH = 4,
  parameter int CNT_WIDTH  = 32,
  parameter int TIMEOUT    = 1024
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NUM_STAGES-1:0]          stall_req,
  input  logic [NUM_STAGES-1:0]          flush_req,
  input  logic [NUM_STAGES*PC_WIDTH-1:0] flush_pc,
  input  logic                           hold_req,
  input  logic [$clog2(NUM_STAGES)-1:0]  hold_stage,
  input  logic [HOLD_WIDTH-1:0]          hold_cycles,
  input  logic                           cnt_clear,
  output logic [NUM_STAGES-1:0]          stall,
  output logic [NUM_STAGES-1:0]          flush,
  output logic [NUM_STAGES-1:0]          bubble,
  output logic                           pc_stall,
  output logic                           pc_redirect,
  output logic [PC_WIDTH-1:0]            pc_redirect_target,
  output logic                           hold_busy,
  output logic [CNT_WIDTH-1:0]           stall_cycles,
  output logic [CNT_WIDTH-1:0]           flush_count,
  output logic                           timeout
);

  localparam int SW = $clog2(NUM_STAGES);

  logic [SW-1:0]         hold_stage_q;
  logic [HOLD_WIDTH-1:0] hold_count;
  logic [31:0]           run_q;
  logic [NUM_STAGES-1:0] eff;
  logic [NUM_STAGES-1:0] stall_mask;
  logic [NUM_STAGES-1:0] flush_mask;
  logic [SW-1:0]         f_idx;
  logic                  f_any;
  logic                  acc;
  logic                  flush_applied;
  logic                  stall_any;

  assign hold_busy = (hold_count != '0);

  // stall_mask[j] is set when any stage at or above j requests a stall,
  // so a flush at f is blocked exactly when stall_mask[f] is set.
  always_comb begin
    eff = stall_req;
    for (int i = 0; i < NUM_STAGES; i++) begin
      if (hold_busy && int'(hold_stage_q) == i) eff[i] = 1'b1;
    end
    acc        = 1'b0;
    stall_mask = '0;
    for (int j = NUM_STAGES - 1; j >= 0; j--) begin
      acc           = acc | eff[j];
      stall_mask[j] = acc;
    end
    f_idx = '0;
    f_any = 1'b0;
    for (int i = 0; i < NUM_STAGES; i++) begin
      if (flush_req[i]) begin
        f_idx = SW'(i);
        f_any = 1'b1;
      end
    end
    flush_mask = '0;
    for (int j = 0; j < NUM_STAGES; j++) begin
      flush_mask[j] = (j < int'(f_idx));
    end
    flush_applied = f_any && !stall_mask[f_idx];
  end

  always_comb begin
    stall              = '0;
    flush              = '0;
    bubble             = '0;
    pc_redirect        = 1'b0;
    pc_redirect_target = '0;
    if (!rst) begin
      if (flush_applied) begin
        flush              = flush_mask;
        pc_redirect        = 1'b1;
        pc_redirect_target = flush_pc[int'(f_idx)*PC_WIDTH +: PC_WIDTH];
      end else begin
        stall = stall_mask;
      end
    end
    for (int j = 1; j < NUM_STAGES; j++) begin
      bubble[j] = stall[j-1] & ~stall[j];
    end
    pc_stall  = stall[0];
    stall_any = |stall;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hold_count   <= '0;
      hold_stage_q <= '0;
      stall_cycles <= '0;
      flush_count  <= '0;
      run_q        <= '0;
      timeout      <= 1'b0;
    end else begin
      // A squash at f kills the held instruction, which is younger than f.
      if (flush_applied) begin
        hold_count <= '0;
      end else if (hold_req && !hold_busy && hold_cycles != '0 &&
                   int'(hold_stage) < NUM_STAGES) begin
        hold_count   <= hold_cycles;
        hold_stage_q <= hold_stage;
      end else if (hold_busy) begin
        hold_count <= hold_count - HOLD_WIDTH'(1);
      end

      if (cnt_clear) begin
        stall_cycles <= '0;
        flush_count  <= '0;
        run_q        <= '0;
        timeout      <= 1'b0;
      end else begin
        if (stall_any && stall_cycles != '1) stall_cycles <= stall_cycles + CNT_WIDTH'(1);
        if (flush_applied && flush_count != '1) flush_count <= flush_count + CNT_WIDTH'(1);
        if (stall_any) begin
          if (run_q < 32'(TIMEOUT)) run_q <= run_q + 32'd1;
          if (TIMEOUT != 0 && run_q >= 32'(TIMEOUT - 1)) timeout <= 1'b1;
        end else begin
          run_q <= '0;
        end
      end
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed test-plan steps followed by
// random traffic, all checked against an arithmetic reference model.
module tb_hazard_ctrl;

  localparam int N   = 5;
  localparam int PCW = 32;
  localparam int HW  = 4;
  localparam int CW  = 32;
  localparam int TO  = 8;

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   stall_req, flush_req;
  logic [N*PCW-1:0] flush_pc;
  logic           hold_req;
  logic [2:0]     hold_stage;
  logic [HW-1:0]  hold_cycles;
  logic           cnt_clear;
  logic [N-1:0]   stall, flush, bubble;
  logic           pc_stall, pc_redirect, hold_busy, timeout;
  logic [PCW-1:0] pc_redirect_target;
  logic [CW-1:0]  stall_cycles, flush_count;

  always #5 clk = ~clk;

  hazard_ctrl #(
    .NUM_STAGES(N), .PC_WIDTH(PCW), .HOLD_WIDTH(HW), .CNT_WIDTH(CW), .TIMEOUT(TO)
  ) dut (
    .clk(clk), .rst(rst), .stall_req(stall_req), .flush_req(flush_req),
    .flush_pc(flush_pc), .hold_req(hold_req), .hold_stage(hold_stage),
    .hold_cycles(hold_cycles), .cnt_clear(cnt_clear), .stall(stall),
    .flush(flush), .bubble(bubble), .pc_stall(pc_stall),
    .pc_redirect(pc_redirect), .pc_redirect_target(pc_redirect_target),
    .hold_busy(hold_busy), .stall_cycles(stall_cycles),
    .flush_count(flush_count), .timeout(timeout)
  );

  int compared = 0;
  int mismatched = 0;

  int m_hold_rem, m_hold_stage, m_stall_cycles, m_flush_count, m_run;
  bit m_timeout;

  logic [N-1:0]   e_stall, e_flush, e_bubble;
  logic           e_redirect;
  logic [PCW-1:0] e_target;
  bit             e_applied;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference: the oldest stalling stage and the oldest flushing stage decide everything.
  task automatic modelComb();
    int top, f;
    logic [N-1:0] eff;
    eff = stall_req;
    if (m_hold_rem > 0) eff[m_hold_stage] = 1'b1;
    top = -1;
    f = -1;
    for (int i = 0; i < N; i++) begin
      if (eff[i]) top = i;
      if (flush_req[i]) f = i;
    end
    e_applied  = (f >= 0) && (top < f);
    e_stall    = '0;
    e_flush    = '0;
    e_bubble   = '0;
    e_redirect = 1'b0;
    e_target   = '0;
    if (!rst) begin
      if (e_applied) begin
        e_flush    = N'((1 << f) - 1);
        e_redirect = 1'b1;
        e_target   = flush_pc[f*PCW +: PCW];
      end else if (top >= 0) begin
        e_stall = N'((1 << (top + 1)) - 1);
        if (top < N - 1) e_bubble = N'(1 << (top + 1));
      end
    end
  endtask

  task automatic applyStimulus(input logic [N-1:0] sr, input logic [N-1:0] fr,
                               input logic hr, input logic [2:0] hs,
                               input logic [HW-1:0] hc, input logic cc, input logic r);
    stall_req   = sr;
    flush_req   = fr;
    hold_req    = hr;
    hold_stage  = hs;
    hold_cycles = hc;
    cnt_clear   = cc;
    rst         = r;
    #2;
  endtask

  task automatic checkOutput();
    modelComb();
    chk("stall", stall, e_stall);
    chk("flush", flush, e_flush);
    chk("bubble", bubble, e_bubble);
    chk("pc_stall", pc_stall, e_stall != 0);
    chk("pc_redirect", pc_redirect, e_redirect);
    if (e_redirect || rst) chk("pc_redirect_target", pc_redirect_target, e_target);
    chk("hold_busy", hold_busy, m_hold_rem > 0);
    chk("stall_cycles", stall_cycles, 64'(m_stall_cycles));
    chk("flush_count", flush_count, 64'(m_flush_count));
    chk("timeout", timeout, m_timeout);
  endtask

  task automatic tick();
    modelComb();
    @(posedge clk);
    if (rst) begin
      m_hold_rem = 0; m_hold_stage = 0; m_stall_cycles = 0;
      m_flush_count = 0; m_run = 0; m_timeout = 0;
    end else begin
      if (e_applied) m_hold_rem = 0;
      else if (hold_req && m_hold_rem == 0 && hold_cycles != 0 && hold_stage < N) begin
        m_hold_rem   = hold_cycles;
        m_hold_stage = hold_stage;
      end else if (m_hold_rem > 0) m_hold_rem--;
      if (cnt_clear) begin
        m_stall_cycles = 0; m_flush_count = 0; m_run = 0; m_timeout = 0;
      end else begin
        if (e_stall != 0) begin
          m_stall_cycles++;
          if (m_run < TO) m_run++;
          if (TO > 0 && m_run >= TO) m_timeout = 1;
        end else m_run = 0;
        if (e_applied) m_flush_count++;
      end
    end
    #1;
  endtask

  initial begin
    flush_pc = '0;
    applyStimulus('0, '0, 0, 0, 0, 0, 1);
    @(posedge clk);
    @(posedge clk);
    #1;
    m_hold_rem = 0; m_hold_stage = 0; m_stall_cycles = 0;
    m_flush_count = 0; m_run = 0; m_timeout = 0;
    checkOutput(); tick();

    applyStimulus(5'b00100, '0, 0, 0, 0, 0, 0); checkOutput();
    chk("tp_stall_a", stall, 5'b00111); chk("tp_bubble_a", bubble, 5'b01000);
    chk("tp_pc_stall_a", pc_stall, 1'b1); tick();
    applyStimulus(5'b10001, '0, 0, 0, 0, 0, 0); checkOutput();
    chk("tp_stall_b", stall, 5'b11111); chk("tp_bubble_b", bubble, 5'b00000); tick();

    flush_pc[3*PCW +: PCW] = 32'h8000_0040;
    applyStimulus('0, 5'b01000, 0, 0, 0, 0, 0); checkOutput();
    chk("tp_flush_a", flush, 5'b00111); chk("tp_target_a", pc_redirect_target, 32'h8000_0040);
    tick();
    applyStimulus('0, '0, 0, 0, 0, 0, 0); checkOutput();
    chk("tp_flush_count", flush_count, 1); tick();

    applyStimulus(5'b01000, 5'b00100, 0, 0, 0, 0, 0); checkOutput();
    chk("tp_deferred_flush", flush, 5'b00000); chk("tp_deferred_stall", stall, 5'b01111); tick();
    applyStimulus('0, 5'b00100, 0, 0, 0, 0, 0); checkOutput();
    chk("tp_released_flush", flush, 5'b00011); tick();

    applyStimulus('0, '0, 1, 3'd2, 4'd3, 0, 0); checkOutput(); tick();
    applyStimulus('0, '0, 0, 0, 0, 0, 0); checkOutput();
    chk("tp_hold_stall", stall, 5'b00111); tick();
    applyStimulus('0, '0, 1, 3'd4, 4'd5, 0, 0); checkOutput(); tick();
    applyStimulus('0, '0, 0, 0, 0, 0, 0); checkOutput(); tick();
    checkOutput(); chk("tp_hold_end", hold_busy, 1'b0); tick();

    applyStimulus('0, '0, 1, 3'd1, 4'd0, 0, 0); checkOutput(); tick();
    applyStimulus('0, '0, 0, 0, 0, 0, 0); checkOutput(); tick();

    applyStimulus('0, '0, 1, 3'd1, 4'd5, 0, 0); checkOutput(); tick();
    applyStimulus('0, '0, 0, 0, 0, 0, 0); checkOutput(); tick();
    applyStimulus('0, 5'b00100, 0, 0, 0, 0, 0); checkOutput(); tick();
    applyStimulus('0, '0, 0, 0, 0, 0, 0); checkOutput();
    chk("tp_hold_cancel", hold_busy, 1'b0); tick();

    applyStimulus('0, '0, 1, 3'd6, 4'd4, 0, 0); checkOutput(); tick();
    applyStimulus('0, '0, 0, 0, 0, 0, 0); checkOutput(); tick();

    applyStimulus('0, '0, 0, 0, 0, 1, 0); checkOutput(); tick();
    repeat (8) begin
      applyStimulus(5'b00001, '0, 0, 0, 0, 0, 0); checkOutput(); tick();
    end
    applyStimulus('0, '0, 0, 0, 0, 0, 0); checkOutput();
    chk("tp_timeout", timeout, 1'b1); chk("tp_stall_cycles", stall_cycles, 8); tick();
    checkOutput(); tick();
    applyStimulus('0, '0, 0, 0, 0, 1, 0); checkOutput(); tick();
    applyStimulus('0, '0, 0, 0, 0, 0, 0); checkOutput();
    chk("tp_clear_timeout", timeout, 1'b0); tick();

    applyStimulus('0, '0, 1, 3'd3, 4'd6, 0, 0); checkOutput(); tick();
    applyStimulus(5'b00010, 5'b10000, 0, 0, 0, 0, 1); checkOutput();
    chk("tp_rst_stall", stall, 5'b00000); tick();
    applyStimulus('0, '0, 0, 0, 0, 0, 0); checkOutput(); tick();

    repeat (400) begin
      logic [N-1:0] sr, fr;
      for (int k = 0; k < N; k++) begin
        sr[k] = ($urandom_range(0, 3) == 0);
        fr[k] = ($urandom_range(0, 7) == 0);
        flush_pc[k*PCW +: PCW] = $urandom();
      end
      applyStimulus(sr, fr, $urandom_range(0, 5) == 0, 3'($urandom_range(0, 7)),
                    HW'($urandom_range(0, 15)), $urandom_range(0, 39) == 0,
                    $urandom_range(0, 59) == 0);
      checkOutput();
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Parametrised pipeline hazard controller: merges per-stage stall and flush requests into per-stage stall, flush and bubble controls plus a PC redirect.
- Adds a self-timed multi-cycle stall hold for fixed-latency units, saturating performance counters and a stall watchdog.
- Sits between the pipeline stages and the PC/fetch unit. Stage 0 = PC/fetch (youngest); stage N-1 = writeback (oldest).

Parameters:
NUM_STAGES, 5, number of pipeline stages N (>=2)
PC_WIDTH, 32, width of redirect PC
HOLD_WIDTH, 4, width of the hold cycle count
CNT_WIDTH, 32, width of the performance counters
TIMEOUT, 1024, consecutive stall cycles before timeout is raised; 0 disables the watchdog

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
stall_req  in  N  stall_req[i]: stage i cannot advance
flush_req  in  N  flush_req[i]: stage i resolved a redirect
flush_pc  in  N*PC_WIDTH  redirect target; slice i = bits [i*PC_WIDTH +: PC_WIDTH]
hold_req  in  1  start a timed hold (1-cycle pulse)
hold_stage  in  clog2(N)  stage index to hold
hold_cycles  in  HOLD_WIDTH  hold length in cycles
cnt_clear  in  1  clears the counters and timeout
stall  out  N  stall[j]: stage j holds its register
flush  out  N  flush[j]: stage j is squashed
bubble  out  N  bubble[j]: stage j register loads a NOP
pc_stall  out  1  PC holds
pc_redirect  out  1  PC loads pc_redirect_target
pc_redirect_target  out  PC_WIDTH  redirect PC
hold_busy  out  1  timed hold active
stall_cycles  out  CNT_WIDTH  cycles with any stall
flush_count  out  CNT_WIDTH  applied flushes
timeout  out  1  sticky watchdog flag

Behaviour:
- Reset: hold inactive, hold counter 0, counters 0, timeout 0. All combinational outputs (stall, flush, bubble, pc_stall, pc_redirect, pc_redirect_target) are forced to 0 while rst=1.
- Effective request: eff[i] = stall_req[i] | (hold_busy & hold_stage_q==i).
- Stall: top = highest i with eff[i]. stall[j]=1 for all j<=top; otherwise stall=0. The highest requester wins; the stall is the superset of all requests.
- Flush: f = highest i with flush_req[i], so the oldest stage wins.
  - Applied when no eff[i] exists with i>=f: flush[j]=1 for j<f; flush[f]=0. Stall is forced to all-zero that cycle. pc_redirect=1, pc_redirect_target=flush_pc slice f.
  - Deferred when any eff[i] exists with i>=f: flush=0, pc_redirect=0, normal stall applies. The requester holds flush_req until applied.
  - flush_req[0] alone: no stage is squashed; the redirect still applies.
- bubble[0]=0. bubble[j] = stall[j-1] & ~stall[j] for j>=1.
- pc_stall = stall[0]. All of the above are combinational, with zero latency from the requests.
- Timed hold:
  - Accepted at a clock edge when hold_req=1, hold_busy=0, hold_cycles!=0 and no flush is applied. This latches hold_stage_q and loads count=hold_cycles.
  - hold_busy=1 from the next cycle for exactly hold_cycles cycles. The count decrements every cycle regardless of stall; hold_busy drops when the count reaches 0.
  - hold_req is ignored while hold_busy=1 or when hold_cycles=0. An out-of-range hold_stage (>=N) is ignored.
  - An applied flush cancels an active hold at that edge (the held instruction is younger than f). hold_busy=0 next cycle.
- Counters:
  - stall_cycles +1 on each edge where stall!=0.
  - flush_count +1 on each edge where a flush is applied.
  - Both saturate at all-ones.
  - cnt_clear=1 clears both, clears timeout and clears the watchdog run counter. Clear has priority over increment.
- Watchdog: a run counter increments while stall!=0 and resets to 0 when stall==0. When it reaches TIMEOUT, timeout<=1 (sticky until rst or cnt_clear). The run counter saturates. TIMEOUT=0 means timeout is never set.
- rst mid-hold or mid-stall: all state is cleared at the edge; outputs are 0 the same cycle.

Test Plan:
- N=5. stall_req=00100 -> stall=00111, bubble=01000, pc_stall=1. stall_req=10001 -> stall=11111, bubble=00000.
- flush_req=01000, flush_pc slice3=0x80000040, no stalls -> flush=00111, stall=00000, pc_redirect=1, target=0x80000040, flush_count 0->1.
- flush_req=00100 with stall_req=01000 -> flush=0, pc_redirect=0, stall=01111. Drop stall_req next cycle -> flush=00011, redirect applied.
- hold_req=1, hold_stage=2, hold_cycles=3 at edge T -> hold_busy and stall=00111 for cycles T+1..T+3, 0 at T+4. A second hold_req at T+2 is ignored. hold_cycles=0 is ignored.
- Hold active on stage 1, flush_req=00100 applied -> hold_busy=0 next cycle, stall=0.
- TIMEOUT=8, stall_req=00001 held 8 cycles -> timeout=1 and stays after release. stall_cycles=8. cnt_clear -> counters=0, timeout=0. Assert rst mid-hold -> all outputs 0.
